// File: rtl/cordic_timing_pkg.sv
// Shared timing constants and monitor state encoding for the CORDIC init
// pulse generator and its receive-side monitor.
package cordic_timing_pkg;

    localparam int DEF_CNT_W    = 10;
    localparam int DEF_EXP_HIGH = 200;
    localparam int DEF_EXP_LOW  = 200;
    localparam int DEF_TIMEOUT  = 600;

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW,
        LOST
    } mon_state_e;

    // True when width w lies in [exp_w - tol, exp_w + tol].
    function automatic logic in_tol(
        input int w,
        input int exp_w,
        input int tol
    );
        return (w >= exp_w - tol) && (w <= exp_w + tol);
    endfunction

endpackage

// File: rtl/cordic_pulse_monitor_if.sv
// Bundle between pulse source / CORDIC control (master) and the monitor (slave).
// pulse_in toward the monitor; strobe, widths and status flags back.
interface cordic_pulse_monitor_if
    import cordic_timing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             pulse_in;
    logic             start_strobe;
    logic [CNT_W-1:0] high_width;
    logic [CNT_W-1:0] low_width;
    logic             meas_valid;
    logic             width_err;
    logic             lost;
    logic             lock;

    modport master (
        output pulse_in,
        input  start_strobe, high_width, low_width,
        input  meas_valid, width_err, lost, lock
    );

    modport slave (
        input  pulse_in,
        output start_strobe, high_width, low_width,
        output meas_valid, width_err, lost, lock
    );
endinterface

// File: rtl/pulse_edge_det.sv
// Edge detector for the init pulse: one-cycle delayed copy plus rise/fall.
// Ports: clk, rst (async active-low), pulse_in; outputs rise, fall.
module pulse_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise,
    output logic fall
);
    logic pulse_d;
    logic armed;

    // armed masks the first sample after reset, so a level already present
    // at reset release is treated as partial rather than as a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            pulse_d <= pulse_in;
            armed   <= 1'b1;
        end
    end

    assign rise = armed & pulse_in & ~pulse_d;
    assign fall = armed & ~pulse_in & pulse_d;
endmodule

// File: rtl/cordic_pulse_monitor.sv
// Measures high/low widths of the CORDIC init pulse, strobes the datapath on
// each rise, flags out-of-tolerance widths, loss of pulse and lock.
// Ports: clk, rst (async active-low), mon (slave side of the monitor bundle).
module cordic_pulse_monitor
    import cordic_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HIGH = DEF_EXP_HIGH,
    parameter int EXP_LOW  = DEF_EXP_LOW,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int LOCK_N   = 4
) (
    input logic                   clk,
    input logic                   rst,
    cordic_pulse_monitor_if.slave mon
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_N);

    mon_state_e state_q;
    mon_state_e state_d;

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_inc;
    logic             high_good;
    logic             tmo;
    logic             rpt_high;
    logic             rpt_low;
    logic             hi_ok;
    logic             lo_ok;

    pulse_edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (mon.pulse_in),
        .rise     (rise),
        .fall     (fall)
    );

    // An edge on the timeout cycle wins, so tmo excludes edges.
    assign tmo = !rise && !fall && (cnt == TMO) && (state_q != LOST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            rise:    state_d = MEAS_HIGH;
            fall:    state_d = MEAS_LOW;
            tmo:     state_d = LOST;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        rpt_high = fall && (state_q == MEAS_HIGH);
        rpt_low  = rise && (state_q == MEAS_LOW);
        hi_ok    = in_tol(int'(cnt), EXP_HIGH, TOL);
        lo_ok    = in_tol(int'(cnt), EXP_LOW, TOL);
        good_inc = (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + GW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt              <= '0;
            good_cnt         <= '0;
            high_good        <= 1'b0;
            mon.start_strobe <= 1'b0;
            mon.high_width   <= '0;
            mon.low_width    <= '0;
            mon.meas_valid   <= 1'b0;
            mon.width_err    <= 1'b0;
            mon.lost         <= 1'b0;
            mon.lock         <= 1'b0;
        end else begin
            mon.start_strobe <= rise;
            mon.meas_valid   <= rpt_high || rpt_low;
            mon.width_err    <= (rpt_high && !hi_ok) ||
                                (rpt_low && !lo_ok);

            if (rise || fall) begin
                cnt      <= CNT_W'(1);
                mon.lost <= 1'b0;
            end else if (cnt != TMO) begin
                cnt <= cnt + 1'b1;
            end

            if (tmo) begin
                mon.lost  <= 1'b1;
                mon.lock  <= 1'b0;
                good_cnt  <= '0;
                high_good <= 1'b0;
            end

            if (rpt_high) begin
                mon.high_width <= cnt;
                high_good      <= hi_ok;
                if (!hi_ok) begin
                    good_cnt <= '0;
                    mon.lock <= 1'b0;
                end
            end

            // The low report closes a period; it only counts toward lock
            // when the high half just before it was also in tolerance.
            if (rpt_low) begin
                mon.low_width <= cnt;
                if (lo_ok && high_good) begin
                    good_cnt <= good_inc;
                    if (good_inc == LOCK_MAX) begin
                        mon.lock <= 1'b1;
                    end
                end else if (!lo_ok) begin
                    good_cnt <= '0;
                    mon.lock <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cordic_pulse_monitor.sv
// Self-checking bench for cordic_pulse_monitor: directed scenarios plus
// randomized pulse widths against a run-length reference model.
module tb_cordic_pulse_monitor;
    localparam int CNT_W    = 10;
    localparam int EXP_HIGH = 200;
    localparam int EXP_LOW  = 200;
    localparam int TOL      = 2;
    localparam int TIMEOUT  = 600;
    localparam int LOCK_N   = 4;

    logic clk;
    logic rst;

    cordic_pulse_monitor_if #(.CNT_W(CNT_W)) ifc ();

    cordic_pulse_monitor #(
        .CNT_W    (CNT_W),
        .EXP_HIGH (EXP_HIGH),
        .EXP_LOW  (EXP_LOW),
        .TOL      (TOL),
        .TIMEOUT  (TIMEOUT),
        .LOCK_N   (LOCK_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    int rises    = 0;
    int ss_seen  = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp_v, $time);
        end
    endtask

    // Reference model: tracks runs of identical samples.
    int run_len;
    bit have_prev;
    bit prev;
    bit run_measured;
    bit m_lost;
    int streak;
    bit last_high_ok;
    int exp_ss, exp_mv, exp_we, exp_hw, exp_lw, exp_lost, exp_lock;

    function automatic bit in_window(input int w, input int e);
        return (w >= e - TOL) && (w <= e + TOL);
    endfunction

    task automatic model_reset();
        run_len = 0; have_prev = 0; prev = 0;
        run_measured = 0; m_lost = 0; streak = 0; last_high_ok = 0;
        exp_ss = 0; exp_mv = 0; exp_we = 0; exp_hw = 0; exp_lw = 0;
        exp_lost = 0; exp_lock = 0;
    endtask

    task automatic model_step(input bit p);
        bit ok;
        exp_ss = 0; exp_mv = 0; exp_we = 0;
        if (have_prev && p != prev) begin
            if (run_measured) begin
                ok = in_window(run_len, prev ? EXP_HIGH : EXP_LOW);
                exp_mv = 1;
                exp_we = !ok;
                if (prev) begin
                    exp_hw = run_len;
                    last_high_ok = ok;
                end else begin
                    exp_lw = run_len;
                    if (ok && last_high_ok) streak++;
                end
                if (!ok) streak = 0;
            end
            exp_ss = p;
            run_len = 1;
            run_measured = 1;
            m_lost = 0;
        end else begin
            run_len++;
            if (run_len == TIMEOUT + 1) begin
                m_lost = 1;
                streak = 0;
                last_high_ok = 0;
                run_measured = 0;
            end
        end
        have_prev = 1;
        prev = p;
        exp_lost = m_lost;
        exp_lock = (streak >= LOCK_N);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step(ifc.pulse_in);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (ifc.start_strobe) ss_seen++;
                chk("start_strobe", int'(ifc.start_strobe), exp_ss);
                chk("meas_valid", int'(ifc.meas_valid), exp_mv);
                chk("width_err", int'(ifc.width_err), exp_we);
                chk("high_width", int'(ifc.high_width), exp_hw);
                chk("low_width", int'(ifc.low_width), exp_lw);
                chk("lost", int'(ifc.lost), exp_lost);
                chk("lock", int'(ifc.lock), exp_lock);
            end
        end
    end

    // Drive level v for n sampled cycles; called and returns at a negedge.
    task automatic hold(input bit v, input int n);
        if (v && !ifc.pulse_in) rises++;
        ifc.pulse_in = v;
        repeat (n) @(negedge clk);
    endtask

    function automatic int rnd_width(input int e);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(e - TOL, e + TOL));
        if (r < 8) return int'($urandom_range(e - 10, e + 10));
        if (r < 9) return int'($urandom_range(TIMEOUT - 5, TIMEOUT + 5));
        return int'($urandom_range(1, 5));
    endfunction

    initial begin
        ifc.pulse_in = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_lock", int'(ifc.lock), 0);
        chk("rst_hw", int'(ifc.high_width), 0);
        chk("rst_lost", int'(ifc.lost), 0);
        rst = 1'b1;
        hold(0, 10);

        // Nominal 200/200 from reset.
        hold(1, 200);
        hold(0, 1);
        chk("p1_mv", int'(ifc.meas_valid), 1);
        chk("p1_hw", int'(ifc.high_width), 200);
        chk("p1_we", int'(ifc.width_err), 0);
        hold(0, 199);
        for (int p = 2; p <= 6; p++) begin
            hold(1, 1);
            if (p == 4) chk("lock_p3", int'(ifc.lock), 0);
            if (p == 5) begin
                chk("lock_p4", int'(ifc.lock), 1);
                chk("lw_p4", int'(ifc.low_width), 200);
            end
            hold(1, 199);
            hold(0, 200);
        end

        // One wide high pulse, then relock.
        hold(1, 1);
        chk("lock_p6", int'(ifc.lock), 1);
        hold(1, 204);
        hold(0, 1);
        chk("err_we", int'(ifc.width_err), 1);
        chk("err_hw", int'(ifc.high_width), 205);
        chk("err_lock", int'(ifc.lock), 0);
        hold(0, 199);
        for (int k = 1; k <= 4; k++) begin
            hold(1, 1);
            if (k == 4) chk("relock_pre", int'(ifc.lock), 0);
            hold(1, 199);
            hold(0, 200);
        end
        hold(1, 1);
        chk("relock", int'(ifc.lock), 1);
        hold(1, 199);

        // Loss of pulse.
        hold(0, 600);
        chk("tmo_pre", int'(ifc.lost), 0);
        hold(0, 1);
        chk("tmo_lost", int'(ifc.lost), 1);
        chk("tmo_lock", int'(ifc.lock), 0);
        hold(0, 49);
        hold(1, 1);
        chk("rec_lost", int'(ifc.lost), 0);
        chk("rec_mv", int'(ifc.meas_valid), 0);
        chk("rec_ss", int'(ifc.start_strobe), 1);
        hold(1, 199);

        // Edge exactly at the timeout count.
        hold(0, 600);
        hold(1, 1);
        chk("edge600_mv", int'(ifc.meas_valid), 1);
        chk("edge600_lw", int'(ifc.low_width), 600);
        chk("edge600_we", int'(ifc.width_err), 1);
        chk("edge600_lost", int'(ifc.lost), 0);
        hold(1, 199);

        // Randomized widths.
        for (int i = 0; i < 24; i++) begin
            hold(0, rnd_width(EXP_LOW));
            hold(1, rnd_width(EXP_HIGH));
        end

        // Reset in the middle of a high level.
        hold(0, 100);
        hold(1, 50);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_ss", int'(ifc.start_strobe), 0);
        chk("ar_hw", int'(ifc.high_width), 0);
        chk("ar_lw", int'(ifc.low_width), 0);
        chk("ar_mv", int'(ifc.meas_valid), 0);
        chk("ar_we", int'(ifc.width_err), 0);
        chk("ar_lost", int'(ifc.lost), 0);
        chk("ar_lock", int'(ifc.lock), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(1, 40);
        hold(0, 1);
        chk("partial_mv", int'(ifc.meas_valid), 0);
        hold(0, 199);
        hold(1, 1);
        chk("post_rst_mv", int'(ifc.meas_valid), 1);
        chk("post_rst_lw", int'(ifc.low_width), 200);
        hold(1, 199);
        hold(0, 200);
        hold(1, 5);

        chk("strobe_count", ss_seen, rises);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_pulse_monitor.md
# cordic_pulse_monitor

Receive-side companion of the CORDIC init timing pulse generator. It samples the periodic init pulse, issues a one-cycle start strobe to the CORDIC datapath on every rising edge, and measures each high and low width in clock cycles. It also flags width errors and loss of pulse, and asserts lock after a run of in-tolerance periods. It sits between the timing generator and the CORDIC control logic, in the same 1 MHz clock domain.

## Interface
Parameters:
- CNT_W, 10, width of the cycle counter and reported widths; must satisfy 2^CNT_W > TIMEOUT
- EXP_HIGH, 200, expected high width in cycles
- EXP_LOW, 200, expected low width in cycles
- TOL, 2, allowed ± deviation in cycles; EXP_HIGH ≥ TOL and EXP_LOW ≥ TOL
- TIMEOUT, 600, cycles without an edge before the pulse is declared lost
- LOCK_N, 4, consecutive good periods required for lock

Ports:
- clk  in  1  system clock (1 MHz)
- rst  in  1  asynchronous active-low reset
- pulse_in  in  1  init timing pulse, synchronous to clk
- start_strobe  out  1  one-cycle pulse per rising edge of pulse_in
- high_width  out  CNT_W  last measured high width
- low_width  out  CNT_W  last measured low width
- meas_valid  out  1  one-cycle strobe: high_width or low_width just updated
- width_err  out  1  one-cycle strobe: the reported width is out of tolerance
- lost  out  1  level: no edge seen for TIMEOUT cycles
- lock  out  1  level: LOCK_N consecutive good periods

## Operation
- pulse_d holds pulse_in delayed one cycle. Rise = pulse_in & ~pulse_d; fall = ~pulse_in & pulse_d.
- States:
  - IDLE: after reset; the first level is partial and is not measured.
  - MEAS_HIGH / MEAS_LOW: counting the current level.
  - LOST: timed out.
- On rise (any state): next state MEAS_HIGH, cnt←1, start_strobe←1.
- On fall (any state): next state MEAS_LOW, cnt←1.
- No edge: cnt increments and saturates at TIMEOUT.
- cnt reaching TIMEOUT in MEAS_HIGH, MEAS_LOW or IDLE: next state LOST, lost←1, lock←0, good_cnt←0.
- Width reporting:
  - A fall in MEAS_HIGH reports high_width←cnt.
  - A rise in MEAS_LOW reports low_width←cnt.
  - Each report sets meas_valid←1.
  - Edges leaving IDLE or LOST report nothing.
- Tolerance check: width in [EXP−TOL, EXP+TOL] is good. Otherwise width_err←1 with the report, good_cnt←0 and lock←0.
- A period completes when low_width is reported. If that low width and the preceding high width are both good, good_cnt increments (saturating at LOCK_N). lock←1 when good_cnt reaches LOCK_N.
- Any edge clears lost.
- Simultaneous cnt==TIMEOUT and an edge: the edge wins and no timeout occurs.

## Timing
- Reset values: all outputs 0, high_width = low_width = 0, cnt = 0, pulse_d = 0, state IDLE.
- A rise is detected at the first clock edge that samples pulse_in=1. start_strobe is high for exactly the following cycle (registered, latency 1).
- Widths count sampled cycles. A generator producing 200 high / 200 low reports high_width=200 and low_width=200.
- meas_valid and width_err are asserted in the same cycle as the output register update, one cycle after edge detection.
- lock rises in the cycle after the LOCK_N-th good low-width report.
- Reset asserted mid-operation clears everything asynchronously. Measurement resumes from IDLE.

## Structure
- Shared package cordic_timing_pkg holds:
  - EXP_HIGH/EXP_LOW/TIMEOUT defaults, also used by the generator
  - the state encoding typedef (IDLE, MEAS_HIGH, MEAS_LOW, LOST)
- Sub-module pulse_edge_det holds the pulse_d register and the rise/fall outputs.
- Counter, FSM and lock logic live in cordic_pulse_monitor.

## Test plan
- Drive 200 high / 200 low from reset for 6 periods:
  - first meas_valid occurs at the first fall with high_width=200
  - lock=1 after the 4th complete period
  - no width_err
  - one start_strobe per rise
- Drive high=205 in one period (tolerance 2): width_err strobe with high_width=205, lock drops, then relocks after 4 further good periods.
- Hold pulse_in low for 600 cycles after lock: lost=1 and lock=0 at cnt=600. The next rise clears lost and produces no low_width report.
- Edge exactly on the cycle cnt reaches 600: no lost, normal report with width 600 and width_err=1.
- Assert rst for 3 cycles mid-high-level: all outputs 0 immediately. The first partial level after release produces no report.
